// File: rtl/four_bit_counter.sv
// Four-bit up counter with count enable, synchronous clamped load and terminal-count flag.
// Define FOUR_BIT_COUNTER_SATURATE_EN to make the counter saturate at MAX_COUNT instead of wrapping.
module four_bit_counter #(
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count_enable,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic       terminal
);

    localparam logic [3:0] MAX_VAL = 4'(MAX_COUNT);

    logic       at_max;
    logic [3:0] load_clamped;
    logic [3:0] next_count;

    assign at_max       = (count == MAX_VAL);
    assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    always_comb begin
        next_count = count;
        if (load) begin
            next_count = load_clamped;
        end else if (count_enable) begin
            if (at_max) begin
`ifdef FOUR_BIT_COUNTER_SATURATE_EN
                next_count = MAX_VAL;
`else
                next_count = 4'd0;
`endif
            end else begin
                next_count = count + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else begin
            count <= next_count;
        end
    end

`ifdef FOUR_BIT_COUNTER_SATURATE_EN
    assign terminal = at_max;
`else
    assign terminal = at_max & count_enable;
`endif

endmodule

// File: tb/tb_four_bit_counter.sv
// Scoreboard bench for four_bit_counter: default instance (MAX_COUNT=15) and a MAX_COUNT=10 instance.
module tb_four_bit_counter;

    logic       clk;
    logic       reset;
    logic       en_a, ld_a, en_b, ld_b;
    logic [3:0] lv_a, lv_b;
    logic [3:0] count_a, count_b;
    logic       term_a, term_b;

    int checks;
    int failures;

    logic [3:0] model_a, model_b;

    typedef struct {
        string      tag;
        bit         is_b;
        logic [3:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    four_bit_counter u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .count_enable (en_a),
        .load         (ld_a),
        .load_value   (lv_a),
        .count        (count_a),
        .terminal     (term_a)
    );

    four_bit_counter #(.MAX_COUNT(10)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .count_enable (en_b),
        .load         (ld_b),
        .load_value   (lv_b),
        .count        (count_b),
        .terminal     (term_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] cnt, input logic en, input logic ld,
                                              input logic [3:0] lv, input logic [3:0] max);
        if (ld)
            return (lv > max) ? max : lv;
        if (en) begin
            if (cnt == max) begin
`ifdef FOUR_BIT_COUNTER_SATURATE_EN
                return max;
`else
                return 4'd0;
`endif
            end
            return cnt + 4'd1;
        end
        return cnt;
    endfunction

    function automatic logic model_term(input logic [3:0] cnt, input logic en, input logic [3:0] max);
`ifdef FOUR_BIT_COUNTER_SATURATE_EN
        return (cnt == max);
`else
        return (cnt == max) && en;
`endif
    endfunction

    // Drive one cycle on both instances: check terminal before the edge, count after it.
    task automatic step(input string tag, input logic ea, input logic la, input logic [3:0] va,
                        input logic eb = 1'b0, input logic lb = 1'b0, input logic [3:0] vb = 4'd0);
        sb_entry_t e;
        en_a = ea; ld_a = la; lv_a = va;
        en_b = eb; ld_b = lb; lv_b = vb;
        #1;
        check_val({tag, "_term_a"}, {3'b0, term_a}, {3'b0, model_term(model_a, ea, 4'd15)});
        check_val({tag, "_term_b"}, {3'b0, term_b}, {3'b0, model_term(model_b, eb, 4'd10)});
        model_a = model_next(model_a, ea, la, va, 4'd15);
        model_b = model_next(model_b, eb, lb, vb, 4'd10);
        sb_q.push_back('{tag: {tag, "_cnt_a"}, is_b: 1'b0, exp: model_a});
        sb_q.push_back('{tag: {tag, "_cnt_b"}, is_b: 1'b1, exp: model_b});
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, e.is_b ? count_b : count_a, e.exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        en_a = 1'b0; ld_a = 1'b0; lv_a = 4'd0;
        en_b = 1'b0; ld_b = 1'b0; lv_b = 4'd0;
        model_a = 4'd0;
        model_b = 4'd0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_hold_cnt", count_a, 4'd0);
        end
        check_val("rst_hold_term", {3'b0, term_a}, 4'd0);
        reset = 1'b1;

        step("idle", 1'b0, 1'b0, 4'd0);
        step("idle", 1'b0, 1'b0, 4'd0);

        for (int i = 0; i < 20; i++)
            step("run", 1'b1, 1'b0, 4'd0);

        for (int i = 0; i < 5; i++)
            step("pause", 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++)
            step("resume", 1'b1, 1'b0, 4'd0);

        step("load9", 1'b1, 1'b1, 4'd9);

        // Assert reset between edges: count must clear without a clock edge.
        en_a  = 1'b1;
        reset = 1'b0;
        model_a = 4'd0;
        model_b = 4'd0;
        #1;
        check_val("midrst_async", count_a, 4'd0);
        check_val("midrst_term", {3'b0, term_a}, 4'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_val("midrst_hold", count_a, 4'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++)
            step("post_rst", 1'b1, 1'b0, 4'd0);

        step("load_prio", 1'b1, 1'b1, 4'd12);
        step("load_noen", 1'b0, 1'b1, 4'd3);
        step("load15", 1'b0, 1'b1, 4'd15);
        step("wrap15", 1'b1, 1'b0, 4'd0);

        step("b_clamp", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd14);
        for (int i = 0; i < 14; i++)
            step("b_run", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
        step("b_load7", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7);
        step("b_hold", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
